// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle instruction sequencer for the 8-bit ALU datapath. Each
// instruction is fetched over a request/ack instruction-memory port, its
// operands are read from a 16-entry register file, the ALU is driven with the
// opcode and operands, and the result is written back or the program counter
// is updated from the ALU branch decision.
//
// Instruction word: op=[15:12] a=[11:8] b=[7:4] c=[3:0]
//   0000-0101, 1001 : ALU op, rd=a, rs1=b, rs2=c
//   0110-1000       : branch, rs1=a, rs2=b, c = signed 4-bit PC offset
//   1010            : JMP, target=[7:0]
//   1011-1110       : NOP
//   1111            : HALT
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   start_i                    start at PC 0 (honoured in IDLE and HALT only)
//   imem_req_o/imem_addr_o     fetch request and address (= pc)
//   imem_ack_i/imem_data_i     fetch complete and instruction word
//   rf_raddr1_o/rf_raddr2_o    register-file read addresses
//   rf_rdata1_i/rf_rdata2_i    register-file read data (combinational)
//   rf_we_o/rf_waddr_o/rf_wdata_o  register-file write port
//   alu_inst_o                 ALU opcode (IR.op)
//   alu_reg1_o/alu_reg2_o      ALU operands (A, B)
//   alu_reg_i                  ALU result
//   alu_branch_i               ALU branch decision
//   alu_over_flag_i            ALU add-overflow flag
//   pc_o                       program counter
//   busy_o                     high in every state except IDLE and HALT
//   halted_o                   high in HALT
//   ovf_o                      sticky ADD overflow, cleared by reset or start
// -----------------------------------------------------------------------------
module alu_sequencer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [7:0]  imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic [3:0]  rf_raddr1_o,
    output logic [3:0]  rf_raddr2_o,
    input  logic [7:0]  rf_rdata1_i,
    input  logic [7:0]  rf_rdata2_i,
    output logic        rf_we_o,
    output logic [3:0]  rf_waddr_o,
    output logic [7:0]  rf_wdata_o,
    output logic [3:0]  alu_inst_o,
    output logic [7:0]  alu_reg1_o,
    output logic [7:0]  alu_reg2_o,
    input  logic [7:0]  alu_reg_i,
    input  logic        alu_branch_i,
    input  logic        alu_over_flag_i,
    output logic [7:0]  pc_o,
    output logic        busy_o,
    output logic        halted_o,
    output logic        ovf_o
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  r_q, r_d;
    logic        br_q, br_d;
    logic        ovf_q, ovf_d;

    logic [3:0]  ir_op;
    logic [3:0]  ir_a;
    logic [3:0]  ir_b;
    logic [3:0]  ir_c;

    assign ir_op = ir_q[15:12];
    assign ir_a  = ir_q[11:8];
    assign ir_b  = ir_q[7:4];
    assign ir_c  = ir_q[3:0];

    // ------------------------------------------------------------------
    // Opcode classification and PC arithmetic
    // ------------------------------------------------------------------
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= 4'b0101) || (op == 4'b1001);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == 4'b0110) || (op == 4'b0111) || (op == 4'b1000);
    endfunction

    function automatic logic is_nop(input logic [3:0] op);
        return (op >= 4'b1011) && (op <= 4'b1110);
    endfunction

    // Relative branch target; the 4-bit offset is two's complement and the
    // sum wraps modulo 256 (e.g. 2 + (-8) = 250).
    function automatic logic [7:0] pc_rel(input logic [7:0] pc,
                                          input logic [3:0] off);
        logic signed [7:0] off_s;
        off_s = $signed({{4{off[3]}}, off});
        return pc + $unsigned(off_s);
    endfunction

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    assign imem_req_o  = (state_q == S_FETCH);
    assign imem_addr_o = pc_q;

    // Branches compare a and b; everything else reads b and c.
    assign rf_raddr1_o = is_branch(ir_op) ? ir_a : ir_b;
    assign rf_raddr2_o = is_branch(ir_op) ? ir_b : ir_c;

    // Reset gates the write strobe combinationally so that a reset edge
    // landing on WB can never commit a register write.
    assign rf_we_o    = rst_ni && (state_q == S_WB) && is_alu_op(ir_op);
    assign rf_waddr_o = ir_a;
    assign rf_wdata_o = r_q;

    assign alu_inst_o = ir_op;
    assign alu_reg1_o = a_q;
    assign alu_reg2_o = b_q;

    assign pc_o     = pc_q;
    assign busy_o   = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted_o = (state_q == S_HALT);
    assign ovf_o    = ovf_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    pc_d    = 8'h00;
                    ovf_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // Request and address are held by staying in FETCH.
                if (imem_ack_i) begin
                    ir_d    = imem_data_i;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                a_d = rf_rdata1_i;
                b_d = rf_rdata2_i;
                if (ir_op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_nop(ir_op)) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                r_d  = alu_reg_i;
                br_d = alu_branch_i;
                // Only ADD contributes to the sticky overflow status.
                if ((ir_op == OP_ADD) && alu_over_flag_i) begin
                    ovf_d = 1'b1;
                end
                state_d = S_WB;
            end

            S_WB: begin
                if (is_branch(ir_op)) begin
                    pc_d = br_q ? pc_rel(pc_q, ir_c) : (pc_q + 8'd1);
                end else if (ir_op == OP_JMP) begin
                    pc_d = ir_q[7:0];
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                state_d = S_FETCH;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= 8'h00;
            ir_q    <= 16'h0000;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            r_q     <= 8'h00;
            br_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Bench with behavioural instruction memory (configurable ack wait), register
// file and ALU around alu_sequencer. Expected register writes are queued when
// a program is launched and matched against every rf_we_o pulse.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;
    logic [3:0]  rf_raddr1_o, rf_raddr2_o;
    logic [7:0]  rf_rdata1_i, rf_rdata2_i;
    logic        rf_we_o;
    logic [3:0]  rf_waddr_o;
    logic [7:0]  rf_wdata_o;
    logic [3:0]  alu_inst_o;
    logic [7:0]  alu_reg1_o, alu_reg2_o;
    logic [7:0]  alu_reg_i;
    logic        alu_branch_i;
    logic        alu_over_flag_i;
    logic [7:0]  pc_o;
    logic        busy_o, halted_o, ovf_o;

    alu_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .rf_raddr1_o    (rf_raddr1_o),
        .rf_raddr2_o    (rf_raddr2_o),
        .rf_rdata1_i    (rf_rdata1_i),
        .rf_rdata2_i    (rf_rdata2_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .alu_inst_o     (alu_inst_o),
        .alu_reg1_o     (alu_reg1_o),
        .alu_reg2_o     (alu_reg2_o),
        .alu_reg_i      (alu_reg_i),
        .alu_branch_i   (alu_branch_i),
        .alu_over_flag_i(alu_over_flag_i),
        .pc_o           (pc_o),
        .busy_o         (busy_o),
        .halted_o       (halted_o),
        .ovf_o          (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instruction memory ----------------
    logic [15:0] mem [256];
    int          ack_wait = 0;
    int          wcnt = 0;
    logic        extra_ack = 1'b0;

    assign imem_data_i = mem[imem_addr_o];
    assign imem_ack_i  = (imem_req_o && (wcnt >= ack_wait)) || extra_ack;

    always @(posedge clk) begin
        if (imem_req_o && !imem_ack_i) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end

    // ---------------- register file ----------------
    logic [7:0] rf [16];
    logic       pre_we = 1'b0;
    logic [3:0] pre_addr = 4'd0;
    logic [7:0] pre_data = 8'd0;

    assign rf_rdata1_i = rf[rf_raddr1_o];
    assign rf_rdata2_i = rf[rf_raddr2_o];

    always @(posedge clk) begin
        if (pre_we)       rf[pre_addr]   <= pre_data;
        else if (rf_we_o) rf[rf_waddr_o] <= rf_wdata_o;
    end

    // ---------------- ALU ----------------
    logic [7:0] alu_sum;
    always_comb begin
        alu_sum      = alu_reg1_o + alu_reg2_o;
        alu_reg_i    = 8'h00;
        alu_branch_i = 1'b0;
        case (alu_inst_o)
            4'h0: alu_reg_i = alu_sum;
            4'h1: alu_reg_i = alu_reg1_o - alu_reg2_o;
            4'h2: alu_reg_i = alu_reg1_o & alu_reg2_o;
            4'h3: alu_reg_i = alu_reg1_o | alu_reg2_o;
            4'h4: alu_reg_i = alu_reg1_o + 8'd1;
            4'h5: alu_reg_i = alu_reg1_o ^ alu_reg2_o;
            4'h9: alu_reg_i = {alu_reg1_o[6:0], 1'b0};
            4'h6: alu_branch_i = (alu_reg1_o != alu_reg2_o);
            4'h7: alu_branch_i = (alu_reg1_o == alu_reg2_o);
            4'h8: alu_branch_i = ($signed(alu_reg1_o) < $signed(alu_reg2_o));
            default: alu_reg_i = 8'h00;
        endcase
        // Add-overflow is reported for every opcode; only ADD may latch it.
        alu_over_flag_i = (alu_reg1_o[7] == alu_reg2_o[7]) && (alu_sum[7] != alu_reg1_o[7]);
    end

    // ---------------- write scoreboard ----------------
    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    always @(negedge clk) begin
        if (rf_we_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rf_write", {rf_waddr_o, rf_wdata_o}, 64'hDEAD);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rf_waddr", rf_waddr_o, mon_e.addr);
                chk("rf_wdata", rf_wdata_o, mon_e.data);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start_i   = 1'b0;
        extra_ack = 1'b0;
        rst_ni    = 1'b0;
        tick();
        rst_ni    = 1'b1;
    endtask

    task automatic preload(input logic [7:0] v1, input logic [7:0] v2);
        for (int i = 0; i < 16; i++) begin
            pre_we   = 1'b1;
            pre_addr = 4'(i);
            pre_data = (i == 1) ? v1 : ((i == 2) ? v2 : 8'h00);
            tick();
        end
        pre_we = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 0;
        while (!halted_o && cyc < 600) begin
            tick();
            cyc++;
        end
    endtask

    // Launch from IDLE/HALT and count edges (including the start edge)
    // until halted_o is seen.
    task automatic run_prog(output int cyc);
        int n;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_halt(n);
        cyc = n + 1;
    endtask

    function automatic logic [63:0] all_outs();
        return {3'b0, imem_req_o, imem_addr_o, rf_raddr1_o, rf_raddr2_o, rf_we_o,
                rf_waddr_o, rf_wdata_o, alu_inst_o, alu_reg1_o, alu_reg2_o,
                pc_o, busy_o, halted_o, ovf_o};
    endfunction

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  v1;
        logic [7:0]  v2;
        logic        we;
        logic [3:0]  wa;
        logic [7:0]  wd;
        logic [7:0]  pc;
        logic        ovf;
        int          cyc;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        vecs[0]  = '{16'h0312, 8'h80, 8'h90, 1'b1, 4'd3,  8'h10, 8'd1,   1'b1, 7};
        vecs[1]  = '{16'h0312, 8'h10, 8'h20, 1'b1, 4'd3,  8'h30, 8'd1,   1'b0, 7};
        vecs[2]  = '{16'h1512, 8'h80, 8'h90, 1'b1, 4'd5,  8'hF0, 8'd1,   1'b0, 7};
        vecs[3]  = '{16'h2A12, 8'hF0, 8'h3C, 1'b1, 4'd10, 8'h30, 8'd1,   1'b0, 7};
        vecs[4]  = '{16'h0011, 8'h7F, 8'h00, 1'b1, 4'd0,  8'hFE, 8'd1,   1'b1, 7};
        vecs[5]  = '{16'h7123, 8'h05, 8'h05, 1'b0, 4'd0,  8'h00, 8'd3,   1'b0, 7};
        vecs[6]  = '{16'h7123, 8'h05, 8'h06, 1'b0, 4'd0,  8'h00, 8'd1,   1'b0, 7};
        vecs[7]  = '{16'h7128, 8'h03, 8'h03, 1'b0, 4'd0,  8'h00, 8'd248, 1'b0, 7};
        vecs[8]  = '{16'h6127, 8'h01, 8'h02, 1'b0, 4'd0,  8'h00, 8'd7,   1'b0, 7};
        vecs[9]  = '{16'h8127, 8'h80, 8'h01, 1'b0, 4'd0,  8'h00, 8'd7,   1'b0, 7};
        vecs[10] = '{16'h8127, 8'h01, 8'h80, 1'b0, 4'd0,  8'h00, 8'd1,   1'b0, 7};
        vecs[11] = '{16'hA0FF, 8'h00, 8'h00, 1'b0, 4'd0,  8'h00, 8'd255, 1'b0, 7};
        vecs[12] = '{16'hB000, 8'h00, 8'h00, 1'b0, 4'd0,  8'h00, 8'd1,   1'b0, 5};
        vecs[13] = '{16'hF000, 8'h00, 8'h00, 1'b0, 4'd0,  8'h00, 8'd0,   1'b0, 3};
        vecs[14] = '{16'h9712, 8'h41, 8'h00, 1'b1, 4'd7,  8'h82, 8'd1,   1'b0, 7};
        vecs[15] = '{16'h4811, 8'hFF, 8'h00, 1'b1, 4'd8,  8'h00, 8'd1,   1'b0, 7};

        rst_ni  = 1'b0;
        start_i = 1'b0;
        fill_mem();
        do_reset();
        chk("reset_outputs", all_outs(), 64'h0);

        // ---------------- table-driven single instructions ----------------
        for (int i = 0; i < 16; i++) begin
            do_reset();
            preload(vecs[i].v1, vecs[i].v2);
            fill_mem();
            mem[0]   = vecs[i].instr;
            ack_wait = 0;
            if (vecs[i].we) exp_q.push_back('{vecs[i].wa, vecs[i].wd});
            run_prog(cyc);
            chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("v%0d_halted", i), {busy_o, halted_o}, 2'b01);
            chk($sformatf("v%0d_pc", i), pc_o, vecs[i].pc);
            chk($sformatf("v%0d_ovf", i), ovf_o, vecs[i].ovf);
            chk($sformatf("v%0d_pending_writes", i), exp_q.size(), 0);
            exp_q.delete();
        end

        // ---------------- ADD overflow, cycle by cycle ----------------
        do_reset();
        preload(8'h80, 8'h90);
        fill_mem();
        mem[0] = 16'h0312;
        exp_q.push_back('{4'd3, 8'h10});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("add_c1_req", {imem_req_o, busy_o, rf_we_o}, 3'b110);
        tick();
        chk("add_c2_we", rf_we_o, 1'b0);
        tick();
        chk("add_c3_we", rf_we_o, 1'b0);
        tick();
        chk("add_c4_we", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, 4'd3, 8'h10});
        chk("add_c4_ovf", ovf_o, 1'b1);
        wait_halt(cyc);
        chk("add_halt_pc", {halted_o, ovf_o, pc_o}, {1'b1, 1'b1, 8'd1});
        chk("add_rf_r3", rf[3], 8'h10);

        // ---------------- backward branch after JMP ----------------
        for (int k = 0; k < 2; k++) begin
            do_reset();
            preload(8'h05, (k == 0) ? 8'h05 : 8'h06);
            fill_mem();
            mem[0] = 16'hA004;
            mem[4] = 16'h712E;
            run_prog(cyc);
            chk($sformatf("bra%0d_cycles", k), cyc, 11);
            chk($sformatf("bra%0d_pc", k), pc_o, (k == 0) ? 8'd2 : 8'd5);
        end

        // ---------------- JMP to 0xFF and wrap ----------------
        do_reset();
        preload(8'h22, 8'h00);
        fill_mem();
        mem[0]   = 16'hA0FF;
        mem[255] = 16'h4011;
        exp_q.push_back('{4'd0, 8'h23});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("wrap_fetch_ff", {imem_req_o, imem_addr_o}, {1'b1, 8'hFF});
        for (int k = 0; k < 3; k++) tick();
        chk("wrap_wb", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, 4'd0, 8'h23});
        tick();
        chk("wrap_pc0", {imem_req_o, pc_o}, {1'b1, 8'h00});
        chk("wrap_rf_r0", rf[0], 8'h23);

        // ---------------- fetch wait states ----------------
        do_reset();
        preload(8'h01, 8'h02);
        fill_mem();
        mem[0]   = 16'h0312;
        ack_wait = 3;
        exp_q.push_back('{4'd3, 8'h03});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("wait_req_c%0d", k), {imem_req_o, imem_addr_o}, {1'b1, 8'h00});
            tick();
        end
        chk("wait_decode", {imem_req_o, busy_o, rf_we_o}, 3'b010);
        extra_ack = 1'b1;
        tick();
        extra_ack = 1'b0;
        chk("wait_exec", {imem_req_o, rf_we_o}, 2'b00);
        tick();
        chk("wait_c7_we", {rf_we_o, rf_wdata_o}, {1'b1, 8'h03});
        wait_halt(cyc);
        chk("wait_halt_pc", {halted_o, pc_o}, {1'b1, 8'd1});
        ack_wait = 0;

        // ---------------- reset during FETCH ----------------
        do_reset();
        preload(8'h80, 8'h90);
        fill_mem();
        mem[0]   = 16'h0312;
        ack_wait = 3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("rstf_pending", imem_req_o, 1'b1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("rstf_outputs", all_outs(), 64'h0);
        ack_wait  = 0;
        extra_ack = 1'b1;
        tick();
        extra_ack = 1'b0;
        chk("rstf_late_ack", all_outs(), 64'h0);

        // ---------------- reset during WB ----------------
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        chk("rstw_ovf_set", ovf_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("rstw_we_gated", rf_we_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        chk("rstw_outputs", all_outs(), 64'h0);
        chk("rstw_no_write", rf[3], 8'h00);
        mem[0] = 16'hF000;
        run_prog(cyc);
        chk("rstw_restart", {cyc[7:0], pc_o, ovf_o, halted_o}, {8'd3, 8'd0, 1'b0, 1'b1});

        // ---------------- NOP with start held high ----------------
        do_reset();
        fill_mem();
        for (int k = 0; k < 4; k++) mem[k] = 16'hB000;
        start_i = 1'b1;
        tick();
        tick();
        tick();
        chk("nop_pc1", {busy_o, pc_o}, {1'b1, 8'd1});
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("nop_busy_%0d", k), busy_o, 1'b1);
        end
        chk("nop_pc3", pc_o, 8'd3);
        start_i = 1'b0;
        wait_halt(cyc);
        chk("nop_halt_pc", {halted_o, pc_o}, {1'b1, 8'd4});

        chk("final_pending_writes", exp_q.size(), 0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle instruction sequencer for the 8-bit ALU datapath. It fetches 16-bit instructions over a request/ack instruction-memory port and reads operands from a 16-entry register file. It drives the ALU's opcode and operand inputs, then writes back results or updates the program counter from the ALU's branch output. It sits between instruction memory, the register file and the ALU, and is the only block that sequences the ALU.

## Interface
Parameters:
- none; all widths fixed: 8-bit data/PC, 16-bit instruction, 4-bit register index.

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_ni  in  1  synchronous reset, active-low
- start_i  in  1  begin execution at PC 0; sampled in IDLE and HALT only
- imem_req_o  out  1  fetch request
- imem_addr_o  out  8  fetch address (= pc)
- imem_ack_i  in  1  fetch complete; imem_data_i valid this cycle
- imem_data_i  in  16  instruction word
- rf_raddr1_o / rf_raddr2_o  out  4 each  register-file read addresses (combinational read)
- rf_rdata1_i / rf_rdata2_i  in  8 each  read data
- rf_we_o  out  1  write enable
- rf_waddr_o  out  4  write address
- rf_wdata_o  out  8  write data
- alu_inst_o  out  4  ALU opcode
- alu_reg1_o / alu_reg2_o  out  8 each  ALU operands
- alu_reg_i  in  8  ALU result
- alu_branch_i  in  1  ALU branch decision
- alu_over_flag_i  in  1  ALU add-overflow flag
- pc_o  out  8  current program counter
- busy_o  out  1  high in every state except IDLE and HALT
- halted_o  out  1  high in HALT
- ovf_o  out  1  sticky overflow status

## Operation
Instruction fields in IR: op=[15:12], a=[11:8], b=[7:4], c=[3:0].
- ALU ops 0000–0101 and 1001: rd=a, rs1=b, rs2=c.
- Branches 0110/0111/1000: rs1=a, rs2=b, c = signed 4-bit PC offset.
- 1010 JMP: target=[7:0].
- 1111 HALT.
- 1011–1110 NOP.

States and transitions:
- IDLE:
  - On start_i: pc<=0, ovf<=0, go to FETCH.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc, both held stable until ack.
  - On imem_ack_i: IR<=imem_data_i, go to DECODE.
- DECODE:
  - rf_raddr1_o=IR.a for branches, else IR.b.
  - rf_raddr2_o=IR.b for branches, else IR.c.
  - A<=rf_rdata1_i, B<=rf_rdata2_i.
  - HALT goes to HALT.
  - NOP: pc<=pc+1, go to FETCH.
  - All other opcodes go to EXEC.
- EXEC:
  - alu_inst_o=IR.op, alu_reg1_o=A, alu_reg2_o=B.
  - R<=alu_reg_i, BR<=alu_branch_i.
  - If op=0000 and alu_over_flag_i, set ovf.
  - Go to WB.
- WB:
  - ALU ops: rf_we_o=1, rf_waddr_o=IR.a, rf_wdata_o=R, pc<=pc+1.
  - Branches: pc<=BR ? pc+sext(IR.c) : pc+1.
  - JMP: pc<=IR[7:0].
  - Go to FETCH.
- HALT:
  - Holds pc and all state.
  - start_i restarts exactly as from IDLE.

Rules:
- PC arithmetic is modulo 256 and wraps silently: 255+1=0; 2+sext(4'b1000)=250.
- Register 0 is an ordinary writable register.
- rf_we_o is high only in WB of an ALU op, for exactly one cycle per instruction.
- alu_inst_o, alu_reg1_o and alu_reg2_o are driven from IR.op, A and B in every state; the ALU result is consumed only in EXEC.
- ovf_o is cleared only by reset or start; overflow on any other opcode is ignored.

## Timing
- Reset values:
  - state=IDLE, pc=0, IR=0, A=B=R=0, BR=0, ovf=0.
  - All outputs 0: imem_req_o, rf_we_o, busy_o, halted_o, alu_inst_o=0000, operands=0.
- Handshake:
  - imem_req_o rises the cycle after entry to FETCH decision, i.e. in the first FETCH cycle.
  - Address is stable while req=1 and ack=0.
  - Ack with zero wait is accepted in the same cycle as req.
  - imem_ack_i outside FETCH is ignored.
- Latency with zero-wait ack:
  - ALU op, branch or JMP: 4 cycles (FETCH, DECODE, EXEC, WB).
  - NOP: 2 cycles.
  - HALT: halted_o is high 2 cycles after FETCH.
  - Each wait cycle adds 1.
- start_i while busy is ignored.
- Reset mid-operation (any state, including a pending fetch):
  - Next edge returns to IDLE with reset values.
  - No register write occurs.
  - An ack arriving after reset is ignored.

## Test plan
- ADD overflow: r1=0x80, r2=0x90; mem[0]=0x0312 (ADD r3,r1,r2), mem[1]=0xF000, ack zero-wait, start.
  - Required: rf write r3=0x10 at cycle 4 of execution.
  - Required: ovf_o=1, then halted_o=1 with pc=1.
- Branch taken backwards: r1=r2=5; mem[4]=0x712E (BEQ r1,r2,-2).
  - Required: pc goes 4 -> 2, with no rf write.
  - Same instruction with r2=6: pc goes 4 -> 5.
- JMP and wrap: mem[0]=0xA0FF, mem[255]=0x4011 (INC r0,r1).
  - Required: fetch at address 0xFF, then r0=r1+1, then pc wraps to 0.
- Fetch wait states: ack delayed 3 cycles.
  - Required: imem_req_o and imem_addr_o stable for 4 cycles.
  - Required: instruction completes in 7 cycles; an extra ack in DECODE is ignored.
- Reset during FETCH and during WB: rst_ni low for one edge.
  - Required: all outputs 0 and IDLE next cycle; no write; start_i then restarts at pc=0 with ovf_o=0.
- NOP and start while busy: mem[0]=0xB000, start_i held high throughout.
  - Required: pc=1 after 2 cycles; busy_o stays high; no restart occurs.
